// File: rtl/cry_detect_sched.sv
// cry_detect_sched: round-robin scheduler that time-shares one 1-0-1 serial detector
// among NCH channels, counting hits per frame and raising sticky per-channel alarms.
`default_nettype none

module cry_detect_sched #(
  parameter int NCH        = 4,
  parameter int FRAME_BITS = 16,
  parameter int ALARM_HITS = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] i_ch_req,
  input  logic [NCH-1:0] i_ch_bit,
  output logic [NCH-1:0] o_gnt,
  output logic           o_bit_rd,
  output logic           o_det_rstn,
  output logic           o_det_in,
  input  logic           i_det_out,
  output logic           o_frame_done,
  output logic [4:0]     o_frame_hits,
  output logic [NCH-1:0] o_alarm,
  input  logic [NCH-1:0] i_alarm_ack,
  output logic           o_busy
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  r_last;
  logic [4:0]     r_bit_cnt;
  logic [4:0]     r_hits;
  logic [3:0]     r_acc [NCH];
  logic [NCH-1:0] r_gnt;
  logic           r_bit_rd;
  logic           r_det_rstn;
  logic           r_frame_done;
  logic [4:0]     r_frame_hits;
  logic [NCH-1:0] r_alarm;
  logic           r_busy;

  logic [IW:0]    w_pick;
  logic [4:0]     w_hits_inc;
  logic [3:0]     w_base;
  logic [5:0]     w_sum;
  logic [3:0]     w_new_acc;

  // Returns {found, index}; search starts one past the last served channel.
  function automatic logic [IW:0] f_pick(input logic [NCH-1:0] req, input logic [IW-1:0] last);
    logic [IW:0] res;
    int          c;
    res = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      c = int'(last) + 1 + k;
      if (c >= NCH) c = c - NCH;
      if (req[IW'(c)]) res = {1'b1, IW'(c)};
    end
    return res;
  endfunction

  always_comb begin
    w_pick     = f_pick(i_ch_req, r_last);
    w_hits_inc = (i_det_out && (r_hits != 5'd31)) ? r_hits + 5'd1 : r_hits;
    // A coincident ack restarts the accumulator before this frame's hits land.
    w_base     = i_alarm_ack[r_idx] ? 4'd0 : r_acc[r_idx];
    w_sum      = {2'b00, w_base} + {1'b0, r_hits};
    w_new_acc  = (w_sum > 6'd15) ? 4'd15 : w_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last       <= IW'(NCH - 1);
      r_bit_cnt    <= '0;
      r_hits       <= '0;
      r_gnt        <= '0;
      r_bit_rd     <= 1'b0;
      r_det_rstn   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_hits <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_hits <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pick[IW]) begin
            r_idx      <= w_pick[IW-1:0];
            r_gnt      <= NCH'(1) << w_pick[IW-1:0];
            r_bit_cnt  <= '0;
            r_hits     <= '0;
            r_bit_rd   <= 1'b1;
            r_det_rstn <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
          r_hits    <= w_hits_inc;
          if (r_bit_cnt == 5'(FRAME_BITS - 1)) begin
            r_bit_rd <= 1'b0;
            r_gnt    <= '0;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_hits       <= w_hits_inc;
          r_frame_hits <= w_hits_inc;
          r_frame_done <= 1'b1;
          r_det_rstn   <= 1'b0;
          r_state      <= S_DONE;
        end
        default: begin
          r_last  <= r_idx;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int j = 0; j < NCH; j++) r_acc[j] <= '0;
      r_alarm <= '0;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if ((r_state == S_DONE) && (r_idx == IW'(j))) begin
          r_acc[j]   <= w_new_acc;
          r_alarm[j] <= (r_alarm[j] & ~i_alarm_ack[j]) | (w_new_acc >= 4'(ALARM_HITS));
        end else if (i_alarm_ack[j]) begin
          r_acc[j]   <= '0;
          r_alarm[j] <= 1'b0;
        end
      end
    end
  end

  assign o_gnt        = r_gnt;
  assign o_bit_rd     = r_bit_rd;
  assign o_det_rstn   = r_det_rstn;
  assign o_det_in     = r_bit_rd & i_ch_bit[r_idx];
  assign o_frame_done = r_frame_done;
  assign o_frame_hits = r_frame_hits;
  assign o_alarm      = r_alarm;
  assign o_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cry_detect_sched.sv
// tb_cry_detect_sched: directed bench with a behavioural 1-0-1 detector, per-channel
// bit sources and a frame scoreboard checked on every frame_done.
`default_nettype none

module tb_cry_detect_sched;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NCH-1:0] ch_req;
  logic [NCH-1:0] ch_bit;
  logic [NCH-1:0] gnt;
  logic           bit_rd;
  logic           det_rstn;
  logic           det_in;
  logic           det_out;
  logic           frame_done;
  logic [4:0]     frame_hits;
  logic [NCH-1:0] alarm;
  logic [NCH-1:0] alarm_ack;
  logic           busy;

  cry_detect_sched #(.NCH(NCH), .FRAME_BITS(16), .ALARM_HITS(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_ch_req    (ch_req),
    .i_ch_bit    (ch_bit),
    .o_gnt       (gnt),
    .o_bit_rd    (bit_rd),
    .o_det_rstn  (det_rstn),
    .o_det_in    (det_in),
    .i_det_out   (det_out),
    .o_frame_done(frame_done),
    .o_frame_hits(frame_hits),
    .o_alarm     (alarm),
    .i_alarm_ack (alarm_ack),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Non-overlapping 1-0-1 Moore detector: 0=idle, 1=saw 1, 2=saw 10, 3=found.
  logic [1:0] dst = 2'd0;
  always @(posedge clk) begin
    if (!det_rstn) dst <= 2'd0;
    else case (dst)
      2'd0:    dst <= det_in ? 2'd1 : 2'd0;
      2'd1:    dst <= det_in ? 2'd1 : 2'd2;
      2'd2:    dst <= det_in ? 2'd3 : 2'd0;
      default: dst <= det_in ? 2'd1 : 2'd0;
    endcase
  end
  assign det_out = (dst == 2'd3);

  // Bit sources: each channel replays its 16-bit pattern MSB-first from the start of a grant.
  logic [15:0] pat [NCH];
  logic [4:0]  ptr [NCH];
  initial for (int j = 0; j < NCH; j++) ptr[j] = 5'd0;
  always @(posedge clk) begin
    for (int j = 0; j < NCH; j++) begin
      if (!gnt[j])     ptr[j] <= 5'd0;
      else if (bit_rd) ptr[j] <= ptr[j] + 5'd1;
    end
  end
  always_comb begin
    ch_bit = '0;
    for (int j = 0; j < NCH; j++)
      if (ptr[j] < 5'd16) ch_bit[j] = pat[j][4'(5'd15 - ptr[j])];
  end

  typedef struct {int ch; int hits;} exp_t;
  exp_t sb[$];

  // Scoreboard monitor: grant seen during the frame, frame length and hit count.
  int             fcnt = 0;
  logic [NCH-1:0] fgnt = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      fcnt = 0;
    end else begin
      if (bit_rd) begin
        fcnt++;
        fgnt = gnt;
      end
      if (frame_done) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("frame_hits", 32'(frame_hits), 32'(e.hits));
          chk("frame_grant", 32'(fgnt), 32'(1 << e.ch));
          chk("frame_len", 32'(fcnt), 32'd16);
          chk("gnt_low_in_done", 32'(gnt), 32'd0);
        end
        fcnt = 0;
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!frame_done && lat < 60);
    chk("done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_gnt"},        32'(gnt),        32'd0);
    chk({tag, "_bit_rd"},     32'(bit_rd),     32'd0);
    chk({tag, "_det_rstn"},   32'(det_rstn),   32'd0);
    chk({tag, "_det_in"},     32'(det_in),     32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_hits"}, 32'(frame_hits), 32'd0);
    chk({tag, "_alarm"},      32'(alarm),      32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  task automatic run_frame(input int ch, input int hits, input int exp_lat);
    int lat;
    sb.push_back('{ch, hits});
    ch_req = NCH'(1 << ch);
    wait_done(lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    ch_req = '0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int seen;
    rstn      = 1'b0;
    ch_req    = '0;
    alarm_ack = '0;
    for (int j = 0; j < NCH; j++) pat[j] = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Round-robin from reset: 0,1,2,3,0 with one frame every 19 cycles.
    for (int k = 0; k < 5; k++) sb.push_back('{k % NCH, 0});
    ch_req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_done(lat);
      chk("rr_period", 32'(lat), (k == 0) ? 32'd18 : 32'd19);
    end
    ch_req = '0;
    @(negedge clk);
    chk("rr_alarm", 32'(alarm), 32'd0);

    // Basic 4-hit frame on channel 0 raises alarm[0]; ack clears it.
    pat[0] = 16'hAAAA;
    run_frame(0, 4, 18);
    chk("basic_alarm", 32'(alarm), 32'b0001);
    alarm_ack = 4'b0001;
    @(negedge clk);
    alarm_ack = '0;
    chk("basic_ack", 32'(alarm), 32'd0);

    // Hit completed by the final bit is counted in DRAIN.
    pat[0] = 16'h0005;
    run_frame(0, 1, 18);
    chk("lastbit_alarm", 32'(alarm), 32'd0);

    // Accumulation on channel 2: alarm on the third 1-hit frame.
    pat[2] = 16'h0005;
    for (int k = 0; k < 3; k++) begin
      run_frame(2, 1, 18);
      chk("accum_alarm", 32'(alarm[2]), (k == 2) ? 32'd1 : 32'd0);
    end
    alarm_ack = 4'b0100;
    @(negedge clk);
    alarm_ack = '0;
    chk("accum_ack", 32'(alarm), 32'd0);
    run_frame(2, 1, 18);
    chk("accum_cleared", 32'(alarm[2]), 32'd0);

    // Ack coinciding with channel 1's DONE: the 4-hit update wins.
    pat[1] = 16'hAAAA;
    sb.push_back('{1, 4});
    ch_req = 4'b0010;
    wait_done(lat);
    alarm_ack = 4'b0010;
    ch_req    = '0;
    @(negedge clk);
    alarm_ack = '0;
    chk("collide_alarm", 32'(alarm), 32'b0010);

    // Reset in the middle of a channel 3 frame.
    pat[3] = 16'hAAAA;
    ch_req = 4'b1000;
    seen = 0;
    for (int c = 0; c < 10 && !bit_rd; c++) @(negedge clk);
    chk("midrst_started", 32'(bit_rd), 32'd1);
    repeat (8) @(negedge clk);
    rstn   = 1'b0;
    ch_req = '0;
    @(negedge clk);
    check_reset_outs("midrst");
    rstn = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    for (int j = 0; j < NCH; j++) pat[j] = 16'h0000;
    sb.push_back('{0, 0});
    ch_req = '1;
    wait_done(lat);
    ch_req = '0;
    chk("midrst_latency", 32'(lat), 32'd18);
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/cry_detect_sched.md
# cry_detect_sched

Time-multiplexing scheduler that shares one serial pattern detector (the "1-0-1" cry detector, Moore output, synchronous active-low reset) among NCH microphone channels in the smart-room sensor path. A round-robin arbiter grants one requesting channel a whole frame of FRAME_BITS serial bits. The scheduler clears the detector before each frame, streams the granted channel's bits into it, and counts detector hits. It accumulates hits per channel and raises a sticky per-channel alarm when a threshold is reached.

## Interface
- NCH, 4: number of requesting channels (2..8)
- FRAME_BITS, 16: bits streamed per grant (4..31)
- ALARM_HITS, 3: accumulated hits that set a channel alarm (1..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- ch_req  in  NCH  per-channel level: a full frame is ready
- ch_bit  in  NCH  per-channel current serial bit; head-of-stream, valid while granted
- gnt  out  NCH  one-hot grant, held for the whole frame
- bit_rd  out  1  pop strobe to the granted channel; one bit consumed per high cycle
- det_rstn  out  1  to detector rstn
- det_in  out  1  to detector in
- det_out  in  1  from detector out
- frame_done  out  1  one-cycle pulse at end of frame
- frame_hits  out  5  hits in the finished frame; valid with frame_done
- alarm  out  NCH  sticky per-channel alarm
- alarm_ack  in  NCH  per-channel clear
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - det_rstn=0, holding the detector in its idle state.
  - If any ch_req is high, pick a winner by round-robin starting at (last+1) mod NCH.
  - Register gnt, set bit_cnt=0 and hits=0, then go to RUN.
- **RUN**
  - det_rstn=1, bit_rd=1, det_in = ch_bit[granted index].
  - bit_cnt increments each cycle. After FRAME_BITS cycles, go to DRAIN.
  - hits increments in every cycle where det_out=1.
- **DRAIN** (1 cycle)
  - det_rstn=1, bit_rd=0, det_in=0.
  - Sample det_out once more, to catch a hit completed by the last bit.
- **DONE** (1 cycle)
  - gnt=0, det_rstn=0, frame_done=1, frame_hits=hits, last = granted index.
  - acc[i] = min(acc[i]+hits, 15).
  - If the new acc[i] >= ALARM_HITS, set alarm[i]. Then go to IDLE.
- **alarm_ack[j]** (any state): clears alarm[j] and acc[j] at the next edge.
  - Exception: if it coincides with a DONE update of the same channel, the update wins. acc = min(hits,15), and alarm is set if that value >= ALARM_HITS.
- **ch_req** is sampled only in IDLE. Dropping ch_req mid-frame is ignored; the frame completes and the source must keep supplying bits.
- **Width rules:** hits saturates at 31; acc is 4 bits, saturating at 15.
- **Reset values:** state=IDLE, gnt=0, bit_rd=0, det_in=0, det_rstn=0, frame_done=0, frame_hits=0, alarm=0, acc=0, last=NCH-1 (channel 0 wins first).
- **Reset mid-frame:** abandons the frame. No acc/alarm update and no frame_done.

## Timing
- Request seen in IDLE at cycle t:
  - gnt and bit_rd high from t+1 through t+FRAME_BITS.
  - DRAIN at t+FRAME_BITS+1.
  - DONE/frame_done at t+FRAME_BITS+2.
  - IDLE at t+FRAME_BITS+3.
- Service rate: one frame per FRAME_BITS+3 cycles (19 with defaults).
- Bit k is presented on det_in in RUN cycle k.
- A hit completed by bit k appears on det_out in RUN cycle k+1, or in DRAIN for the last bit.
- det_out pulses last exactly one cycle, so each pulse counts once.
- alarm and acc change at the edge ending DONE; alarm is visible in the IDLE cycle that follows.

## Test plan
- **Basic hit, channel 0:** ch_req=0001, stream 1010_1010_1010_1010.
  - gnt=0001 for 16 cycles; frame_done with frame_hits=4.
  - acc0 reaches 4, so alarm[0]=1.
- **Last-bit hit:** stream 0000_0000_0000_0101.
  - frame_hits=1, counted in DRAIN; alarm stays 0.
- **Round-robin:** ch_req=1111 held, all-zero streams.
  - Grant order 0,1,2,3,0; frame_done every 19 cycles.
  - frame_hits=0 each time.
- **Accumulation:** channel 2 sends three frames with 1 hit each (0000_0000_0000_0101).
  - alarm[2] stays 0 after frames 1 and 2 and rises after frame 3.
  - alarm_ack[2] clears alarm[2] and acc[2] at the next edge.
- **Ack/update collision:** alarm_ack[1] asserted exactly in DONE of a 4-hit channel-1 frame.
  - acc1=4 and alarm[1] stays set.
- **Reset mid-RUN:** rstn=0 at bit 8.
  - All outputs return to reset values and det_rstn=0, with no frame_done.
  - The next request is granted to channel 0.
